decoder: RTL and testbench

Serial-to-parallel receiver for the HSI link. It sits directly downstream of the coder, on the same `clk`/`clk_en` bit tick, and recovers 11-bit frames from the serial line: start 0, 8 data bits, odd-parity bit, stop 1. It checks each frame, delivers the byte through a level-valid / read-acknowledge handshake, and reports parity, framing and overrun errors.

---
 rtl/decoder.sv | 164 ++++++++++++++++
 tb/tb_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// rtl/decoder.sv - HSI link serial-to-parallel frame receiver
//
// Recovers 11-bit frames (start 0, 8 data bits, odd parity, stop 1) sampled
// once per clk_en tick, and delivers each byte through a level-valid /
// read-acknowledge handshake.
//
// Optional feature macro: DECODER_PARITY_CHECK_EN
//   defined     : parity accumulator present, par_err reports bad parity
//   not defined : accumulator removed, par_err tied to 0 (PARITY tick kept)
//
// Parameters:
//   MSB_FIRST - 0: data bit 0 arrives first; 1: data bit 7 arrives first
// Ports:
//   clk      - system clock
//   n_rst    - asynchronous active-low reset
//   clk_en   - bit tick, one line sample per asserted cycle
//   d        - serial line, idles high
//   rd       - read acknowledge pulse, sampled every clk
//   q        - received byte, held until the next delivery
//   q_rdy    - q valid, held until rd
//   par_err  - parity error of the byte currently in q
//   frm_err  - sticky, a stop bit was sampled low
//   ovr      - sticky, a frame completed while q_rdy was high
//   busy     - receiver is not idle

module decoder #(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clk_en,
    input  logic       d,
    input  logic       rd,
    output logic [7:0] q,
    output logic       q_rdy,
    output logic       par_err,
    output logic       frm_err,
    output logic       ovr,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    logic [2:0] state;
    logic [7:0] sr;
    logic [2:0] cnt;
    logic [7:0] sr_next;
    logic       deliver;

    assign sr_next = (MSB_FIRST != 0) ? {sr[6:0], d} : {d, sr[7:1]};

    // A good stop bit lands in q unless an unread byte is already there;
    // an rd on the same edge frees the holding register first.
    assign deliver = clk_en && (state == ST_STOP) && d && (!q_rdy || rd);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            sr      <= 8'h00;
            cnt     <= 3'd0;
            q       <= 8'h00;
            q_rdy   <= 1'b0;
            frm_err <= 1'b0;
            ovr     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (rd) begin
                q_rdy   <= 1'b0;
                frm_err <= 1'b0;
                ovr     <= 1'b0;
            end
            if (clk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!d) begin
                            state <= ST_DATA;
                            cnt   <= 3'd0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        sr  <= sr_next;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (d) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            if (deliver) begin
                                q     <= sr;
                                q_rdy <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                            state   <= ST_BREAK;
                        end
                    end
                    ST_BREAK: begin
                        // The first high sample ends the break; it is not a start bit.
                        if (d) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DECODER_PARITY_CHECK_EN
    logic acc;
    logic par_err_r;

    // acc collects data bits and the parity bit; odd parity leaves it at 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc       <= 1'b0;
            par_err_r <= 1'b0;
        end else begin
            if (rd) begin
                par_err_r <= 1'b0;
            end
            if (clk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!d) begin
                            acc <= 1'b0;
                        end
                    end
                    ST_DATA, ST_PARITY: begin
                        acc <= acc ^ d;
                    end
                    default: begin
                    end
                endcase
            end
            if (deliver) begin
                par_err_r <= ~acc;
            end
        end
    end

    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - directed self-checking bench for decoder

module tb_decoder;

    logic       clk;
    logic       n_rst;
    logic       clk_en;
    logic       d;
    logic       rd;
    logic [7:0] q0, q1;
    logic       q_rdy0, q_rdy1;
    logic       par_err0, par_err1;
    logic       frm_err0, frm_err1;
    logic       ovr0, ovr1;
    logic       busy0, busy1;

    int checks = 0;
    int errors = 0;
    int gap = 0;
    logic exp_par;

    decoder #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .d(d), .rd(rd),
        .q(q0), .q_rdy(q_rdy0), .par_err(par_err0), .frm_err(frm_err0),
        .ovr(ovr0), .busy(busy0)
    );

    decoder #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .d(d), .rd(rd),
        .q(q1), .q_rdy(q_rdy1), .par_err(par_err1), .frm_err(frm_err1),
        .ovr(ovr1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic b);
        d      = b;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        if (gap > 0) begin
            clk_en = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stp,
                              input bit msb, input bit rd_stop);
        tick(1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(msb ? data[7-i] : data[i]);
        end
        tick(par);
        if (rd_stop) rd = 1'b1;
        tick(stp);
        rd = 1'b0;
    endtask

    task automatic do_rd();
        d  = 1'b1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    initial begin
        n_rst  = 1'b0;
        clk_en = 1'b0;
        d      = 1'b1;
        rd     = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_q", q0, 8'h00);
        check("rst_q_rdy", {7'd0, q_rdy0}, 8'd0);
        check("rst_par_err", {7'd0, par_err0}, 8'd0);
        check("rst_frm_err", {7'd0, frm_err0}, 8'd0);
        check("rst_ovr", {7'd0, ovr0}, 8'd0);
        check("rst_busy", {7'd0, busy0}, 8'd0);

        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good frame 0xA5
        tick(1'b0);
        check("a5_busy_start", {7'd0, busy0}, 8'd1);
        for (int i = 0; i < 8; i++) tick(i == 0 || i == 2 || i == 5 || i == 7);
        tick(1'b1);
        tick(1'b1);
        check("a5_q", q0, 8'hA5);
        check("a5_q_rdy", {7'd0, q_rdy0}, 8'd1);
        check("a5_par_err", {7'd0, par_err0}, 8'd0);
        check("a5_busy", {7'd0, busy0}, 8'd0);
        do_rd();
        check("a5_rd_q_rdy", {7'd0, q_rdy0}, 8'd0);
        check("a5_rd_q_hold", q0, 8'hA5);

        // Bad parity 0x01 with parity bit 1
`ifdef DECODER_PARITY_CHECK_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        check("bp_q", q0, 8'h01);
        check("bp_q_rdy", {7'd0, q_rdy0}, 8'd1);
        check("bp_par_err", {7'd0, par_err0}, {7'd0, exp_par});
        do_rd();
        check("bp_rd_par_err", {7'd0, par_err0}, 8'd0);

        // Framing error 0x55, stop 0, break of 5 ticks
        send_frame(8'h55, ~^8'h55, 1'b0, 1'b0, 1'b0);
        check("fe_frm_err", {7'd0, frm_err0}, 8'd1);
        check("fe_q_rdy", {7'd0, q_rdy0}, 8'd0);
        check("fe_busy_stop", {7'd0, busy0}, 8'd1);
        repeat (5) tick(1'b0);
        check("fe_busy_break", {7'd0, busy0}, 8'd1);
        tick(1'b1);
        check("fe_busy_end", {7'd0, busy0}, 8'd0);
        send_frame(8'h3C, ~^8'h3C, 1'b1, 1'b0, 1'b0);
        check("fe_3c_q", q0, 8'h3C);
        check("fe_3c_q_rdy", {7'd0, q_rdy0}, 8'd1);
        check("fe_3c_frm_sticky", {7'd0, frm_err0}, 8'd1);
        do_rd();
        check("fe_rd_frm_err", {7'd0, frm_err0}, 8'd0);

        // Overrun: 0x11 then 0x22 back-to-back
        send_frame(8'h11, ~^8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, ~^8'h22, 1'b1, 1'b0, 1'b0);
        check("ov_q", q0, 8'h11);
        check("ov_ovr", {7'd0, ovr0}, 8'd1);
        check("ov_q_rdy", {7'd0, q_rdy0}, 8'd1);
        do_rd();
        check("ov_rd_q_rdy", {7'd0, q_rdy0}, 8'd0);
        check("ov_rd_ovr", {7'd0, ovr0}, 8'd0);
        send_frame(8'h44, ~^8'h44, 1'b1, 1'b0, 1'b0);
        check("ov_44_q", q0, 8'h44);
        send_frame(8'h33, ~^8'h33, 1'b1, 1'b0, 1'b1);
        check("ov_33_q", q0, 8'h33);
        check("ov_33_q_rdy", {7'd0, q_rdy0}, 8'd1);
        check("ov_33_ovr", {7'd0, ovr0}, 8'd0);
        check("ov_33_par_err", {7'd0, par_err0}, 8'd0);
        do_rd();

        // MSB_FIRST=1 with clk_en every 4th cycle
        gap = 3;
        tick(1'b0);
        for (int i = 0; i < 4; i++) tick(i >= 2);
        repeat (10) @(posedge clk);
        #1;
        check("msb_busy_hold", {7'd0, busy1}, 8'd1);
        check("msb_q_rdy_hold", {7'd0, q_rdy1}, 8'd0);
        for (int i = 4; i < 8; i++) tick(i < 6);
        tick(~^8'h3C);
        tick(1'b1);
        check("msb_q", q1, 8'h3C);
        check("msb_q_rdy", {7'd0, q_rdy1}, 8'd1);
        check("msb_busy", {7'd0, busy1}, 8'd0);
        gap = 0;

        // Reset after the 4th data bit of a frame
        tick(1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1);
        check("mr_busy_pre", {7'd0, busy0}, 8'd1);
        n_rst = 1'b0;
        #1;
        check("mr_q", q0, 8'h00);
        check("mr_q_rdy", {7'd0, q_rdy0}, 8'd0);
        check("mr_busy", {7'd0, busy0}, 8'd0);
        check("mr_q_msb", q1, 8'h00);
        d = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h81, ~^8'h81, 1'b1, 1'b0, 1'b0);
        check("mr_81_q", q0, 8'h81);
        check("mr_81_q_rdy", {7'd0, q_rdy0}, 8'd1);
        check("mr_81_par_err", {7'd0, par_err0}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
